lt24_pic_streamer: RTL and testbench
====================================

Name: lt24_pic_streamer

Overview:
- Downstream consumer of the dual-port picture memory (1200 x 16-bit RGB565 words, a 40x30 tile image).
- Reads the memory through its second port and emits a 320x240 pixel stream, replicating each word into an 8x8 pixel block.
- The stream is delivered over a valid/ready handshake to the LT24 LCD write controller.
- A frame is started by software through a start pulse; busy and done report progress.

Parameters:
- TILE_COLS, 40, words per image row.
- TILE_ROWS, 30, image rows.
- SCALE_LOG2, 3, log2 of replication factor (8 → 8x8 block per word).
- ADDR_W, 11, memory address width.
- DATA_W, 16, pixel/word width.

Ports:
- clk  in  1  single system clock; also drives the memory's second port.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last pixel handshake.
- mem_address  out  ADDR_W  word address to picture memory port 2.
- mem_chipselect  out  1  read strobe; write enable to port 2 is tied low outside this block.
- mem_readdata  in  DATA_W  port-2 read data, valid one clk after address is presented.
- pix_data  out  DATA_W  RGB565 pixel.
- pix_valid  out  1  pixel valid.
- pix_ready  in  1  consumer ready; transfer when pix_valid & pix_ready.
- pix_sof  out  1  high with pixel (0,0) only.
- pix_eol  out  1  high with pixel x = 319 of every line.

Behaviour:
- Reset (async, reset_n low):
  - State goes to IDLE.
  - All outputs are 0: busy, done, pix_valid, pix_sof, pix_eol, mem_chipselect, mem_address, pix_data.
  - All counters clear.
  - A reset mid-frame aborts the frame with no done pulse. After release, the block waits for a new start.
- Counters:
  - x_tile: 0..TILE_COLS-1.
  - x_rep: 0..2^SCALE_LOG2-1.
  - y_line: 0..TILE_ROWS*2^SCALE_LOG2-1.
  - row_base: word address of the current image row, advanced by adding TILE_COLS (no multiplier).
  - Read address = row_base + x_tile, truncated to ADDR_W.
- States:
  - IDLE: on start, clear counters and row_base, set busy, go to FETCH. Otherwise stay.
  - FETCH (1 cycle): drive mem_address, assert mem_chipselect, go to LOAD.
  - LOAD (1 cycle): capture mem_readdata into pix_data, deassert mem_chipselect, assert pix_valid, go to SEND.
  - SEND: hold pix_data, pix_valid, pix_sof and pix_eol stable while pix_ready is low. On each handshake, x_rep increments.
  - SEND, handshake with x_rep at max: x_rep wraps to 0 and x_tile increments. If x_tile was at max, it wraps to 0 and y_line increments. If y_line[SCALE_LOG2-1:0] was all ones, row_base += TILE_COLS.
  - SEND, handshake on the last pixel of a block (not end of frame): pix_valid drops, go to FETCH.
  - SEND, handshake on pixel (319,239): go to DONE.
  - DONE (1 cycle): done = 1, busy clears, go to IDLE.
- Flag timing:
  - pix_sof = (x_tile = 0, x_rep = 0, y_line = 0) while pix_valid.
  - pix_eol = (x_tile = max, x_rep = max) while pix_valid.
- Throughput: at most SCALE+2 cycles per block with pix_ready held high, giving exactly 240 * 40 * 10 = 96000 cycles from FETCH entry to the final handshake.
- Read order: each word is read once per screen line, so each word is read 8 times per frame. No line buffer.
- Boundary rules:
  - start while busy or in DONE is ignored.
  - start in the same cycle as done is ignored.
  - pix_ready high outside SEND has no effect.
  - The largest address issued is 1199; addresses never exceed TILE_COLS*TILE_ROWS-1.
  - The pixel count per frame is exactly 76800.

Test Plan:
- Preload word[a] = a, hold pix_ready = 1, pulse start.
  - 76800 handshakes; pixel (x,y) = (y>>3)*40 + (x>>3).
  - Pixels (0,0) = 0, (8,0) = 1, (0,8) = 40, (319,239) = 1199.
  - pix_sof exactly once, pix_eol 240 times.
  - done one cycle after the last handshake; busy spans 96001 cycles.
- Random pix_ready (50% duty): pix_data, pix_sof and pix_eol stay stable while valid & !ready; the pixel sequence is identical to the first test.
- Pulse start at cycle 1000 of a running frame: no restart, frame completes with exactly 76800 pixels and one done.
- Drive reset_n low for 3 cycles mid-frame (line 100):
  - All outputs are 0 asynchronously; no done pulse.
  - A fresh start yields pixel (0,0) = 0 with pix_sof.
- Memory filled with 0xF800 except word 1199 = 0x001F: the last 8 pixels of lines 232..239 equal 0x001F, and the last pixel carries pix_eol.
- mem_address monitor: never exceeds 1199, and mem_chipselect is high for exactly one cycle per FETCH (9600 per frame).

Source files
------------

// File: rtl/lt24_pic_streamer.sv
// Streams the 40x30 tile picture as a 320x240 RGB565 pixel stream, replicating each
// memory word into a 2^SCALE_LOG2 square block; one memory read per block per line.
module lt24_pic_streamer #(
  parameter int TILE_COLS  = 40,
  parameter int TILE_ROWS  = 30,
  parameter int SCALE_LOG2 = 3,
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eol
);

  localparam int REP   = 1 << SCALE_LOG2;
  localparam int LINES = TILE_ROWS * REP;
  localparam int XT_W  = (TILE_COLS > 1) ? $clog2(TILE_COLS) : 1;
  localparam int XR_W  = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
  localparam int YL_W  = (LINES > 1) ? $clog2(LINES) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, DONE} state_t;
  state_t state;

  logic [XT_W-1:0]   x_tile, x_tile_n;
  logic [XR_W-1:0]   x_rep, x_rep_n;
  logic [YL_W-1:0]   y_line, y_line_n;
  logic [ADDR_W-1:0] row_base, row_base_n;
  logic              hs, rep_max, tile_max, line_max, row_end, last;
  logic [YL_W-1:0]   rep_mask;

  // Next-counter values as they would be after a handshake in SEND.
  always_comb begin
    hs         = (state == SEND) && pix_valid && pix_ready;
    rep_mask   = YL_W'(REP - 1);
    rep_max    = (x_rep == XR_W'(REP - 1));
    tile_max   = (x_tile == XT_W'(TILE_COLS - 1));
    line_max   = (y_line == YL_W'(LINES - 1));
    row_end    = ((y_line & rep_mask) == rep_mask);
    last       = rep_max && tile_max && line_max;
    x_rep_n    = rep_max ? '0 : x_rep + 1'b1;
    x_tile_n   = x_tile;
    y_line_n   = y_line;
    row_base_n = row_base;
    if (rep_max) begin
      x_tile_n = tile_max ? '0 : x_tile + 1'b1;
      if (tile_max) begin
        y_line_n = y_line + 1'b1;
        if (row_end) row_base_n = row_base + ADDR_W'(TILE_COLS);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      mem_address    <= '0;
      mem_chipselect <= 1'b0;
      pix_data       <= '0;
      pix_valid      <= 1'b0;
      pix_sof        <= 1'b0;
      pix_eol        <= 1'b0;
      x_tile         <= '0;
      x_rep          <= '0;
      y_line         <= '0;
      row_base       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          x_tile         <= '0;
          x_rep          <= '0;
          y_line         <= '0;
          row_base       <= '0;
          busy           <= 1'b1;
          mem_address    <= '0;
          mem_chipselect <= 1'b1;
          state          <= FETCH;
        end
        FETCH: begin
          mem_chipselect <= 1'b0;
          state          <= LOAD;
        end
        LOAD: begin
          pix_data  <= mem_readdata;
          pix_valid <= 1'b1;
          pix_sof   <= (x_tile == '0) && (x_rep == '0) && (y_line == '0);
          pix_eol   <= tile_max && rep_max;
          state     <= SEND;
        end
        SEND: if (hs) begin
          x_rep    <= x_rep_n;
          x_tile   <= x_tile_n;
          y_line   <= y_line_n;
          row_base <= row_base_n;
          if (last) begin
            pix_valid <= 1'b0;
            pix_sof   <= 1'b0;
            pix_eol   <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else if (rep_max) begin
            // Block finished: re-read the next word, address presented during FETCH.
            pix_valid      <= 1'b0;
            pix_sof        <= 1'b0;
            pix_eol        <= 1'b0;
            mem_address    <= row_base_n + ADDR_W'(x_tile_n);
            mem_chipselect <= 1'b1;
            state          <= FETCH;
          end else begin
            pix_sof <= 1'b0;
            pix_eol <= tile_max && (x_rep_n == XR_W'(REP - 1));
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lt24_pic_streamer.sv
// Directed + randomized bench for lt24_pic_streamer on a small tile geometry with the
// same replication rules; pixels are predicted from the picture array by coordinates.
module tb_lt24_pic_streamer;

  localparam int TC    = 6;
  localparam int TR    = 4;
  localparam int S     = 3;
  localparam int R     = 1 << S;
  localparam int W     = TC * R;
  localparam int H     = TR * R;
  localparam int NPIX  = W * H;
  localparam int NW    = TC * TR;
  localparam int AMAX  = NW - 1;
  localparam int FRAME = H * TC * (R + 2);

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        busy, done;
  logic [10:0] mem_address;
  logic        mem_chipselect;
  logic [15:0] mem_readdata = '0;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic        pix_sof, pix_eol;

  lt24_pic_streamer #(
    .TILE_COLS(TC), .TILE_ROWS(TR), .SCALE_LOG2(S), .ADDR_W(11), .DATA_W(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_readdata(mem_readdata), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_sof(pix_sof), .pix_eol(pix_eol)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [NW];

  // Port-2 model: registered read, data valid one clock after the strobed address.
  always @(posedge clk)
    if (mem_chipselect)
      mem_readdata <= (int'(mem_address) < NW) ? mem[mem_address] : 16'hDEAD;

  int n_assert = 0;
  int n_fail   = 0;

  int npix, nsof, neol, ncs, ndone, nbusy, first_cs, last_hs, done_cyc, nblue;
  logic        last_eol;
  logic [15:0] got [NPIX];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] all_outs();
    return {busy, done, pix_valid, pix_sof, pix_eol, mem_chipselect, mem_address, pix_data};
  endfunction

  // Runs one frame from a start pulse, sampling at falling edges.
  task automatic run_frame(input bit rand_ready, input int restart_cyc,
                           input bit start_on_done, input int abort_pix);
    int cyc;
    int x, y, line, tile;
    bit r, held;
    logic [18:0] held_v;
    logic [15:0] exp_d;
    npix = 0; nsof = 0; neol = 0; ncs = 0; ndone = 0; nbusy = 0;
    first_cs = -1; last_hs = -1; done_cyc = -1; nblue = 0; last_eol = 1'b0;
    cyc = 0; held = 1'b0; held_v = '0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    forever begin
      cyc++;
      if (held)
        chk("hold_stable", {pix_data, pix_sof, pix_eol, pix_valid}, held_v);
      if (busy) nbusy++;
      if (mem_chipselect) begin
        if (first_cs < 0) first_cs = cyc;
        line = ncs / TC;
        tile = ncs % TC;
        chk("fetch_addr", mem_address, (line / R) * TC + tile);
        ncs++;
      end
      if (done) begin ndone++; done_cyc = cyc; end
      start = (cyc == restart_cyc) || (start_on_done && done);
      r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      pix_ready = r;
      held   = pix_valid && !r;
      held_v = {pix_data, pix_sof, pix_eol, pix_valid};
      if (pix_valid && r) begin
        x = npix % W;
        y = npix / W;
        exp_d = mem[(y / R) * TC + (x / R)];
        chk("pixel", {pix_data, pix_sof, pix_eol},
            {exp_d, 1'(x == 0 && y == 0), 1'(x == W - 1)});
        if (npix < NPIX) got[npix] = pix_data;
        if (pix_sof) nsof++;
        if (pix_eol) neol++;
        if (pix_data == 16'h001F) nblue++;
        last_eol = pix_eol;
        last_hs = cyc;
        npix++;
      end
      if (abort_pix >= 0 && npix >= abort_pix) break;
      if (ndone > 0 && cyc >= done_cyc + 3) break;
      if (cyc > 4 * FRAME) begin
        chk("frame_timeout", 64'(ndone), 1);
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    pix_ready = 1'b0;
  endtask

  task automatic chk_full_frame(input string tag, input bit exact_timing);
    chk({tag, "_npix"}, 64'(npix), NPIX);
    chk({tag, "_sof"}, 64'(nsof), 1);
    chk({tag, "_eol"}, 64'(neol), H);
    chk({tag, "_fetches"}, 64'(ncs), TC * H);
    chk({tag, "_done"}, 64'(ndone), 1);
    chk({tag, "_done_lat"}, 64'(done_cyc - last_hs), 1);
    if (exact_timing) begin
      chk({tag, "_cycles"}, 64'(last_hs - first_cs + 1), FRAME);
      chk({tag, "_busy"}, 64'(nbusy), FRAME + 1);
    end
  endtask

  initial begin
    for (int a = 0; a < NW; a++) mem[a] = 16'(a);

    // Reset state
    #3 reset_n = 1'b0;
    #1 chk("reset_outs", all_outs(), '0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Ready high while idle must not produce anything
    pix_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_quiet", {busy, pix_valid, mem_chipselect, done}, '0);
    end
    pix_ready = 1'b0;

    // Frame A: ramp picture, ready held high
    run_frame(1'b0, -1, 1'b0, -1);
    chk_full_frame("A", 1'b1);
    chk("A_px_0_0", got[0], 0);
    chk("A_px_R_0", got[R], 1);
    chk("A_px_0_R", got[R * W], TC);
    chk("A_px_last", got[NPIX - 1], AMAX);
    chk("A_idle_after", busy, 0);

    // Frame B: random ready, same sequence, stability while stalled
    run_frame(1'b1, -1, 1'b0, -1);
    chk_full_frame("B", 1'b0);
    chk("B_px_last", got[NPIX - 1], AMAX);

    // Frame C: start mid-frame and start coinciding with done are ignored
    run_frame(1'b0, 1000, 1'b1, -1);
    chk_full_frame("C", 1'b1);
    chk("C_no_restart", {busy, mem_chipselect}, '0);

    // Frame D: reset in the middle of the frame
    run_frame(1'b0, -1, 1'b0, (H / 2) * W + 1);
    reset_n = 1'b0;
    #1 chk("abort_reset_outs", all_outs(), '0);
    chk("abort_no_done_before", 64'(ndone), 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", {done, busy, pix_valid}, '0);
    end
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("abort_waits_start", {done, busy, pix_valid, mem_chipselect}, '0);
    end
    run_frame(1'b0, -1, 1'b0, -1);
    chk_full_frame("E", 1'b1);
    chk("E_px_0_0", got[0], 0);

    // Frame F: solid red, last word blue
    for (int a = 0; a < NW; a++) mem[a] = 16'hF800;
    mem[NW - 1] = 16'h001F;
    run_frame(1'b1, -1, 1'b0, -1);
    chk_full_frame("F", 1'b0);
    chk("F_blue_count", 64'(nblue), R * R);
    chk("F_last_px", {got[NPIX - 1], last_eol}, {16'h001F, 1'b1});
    chk("F_px_before_blue", got[NPIX - R - 1], 16'hF800);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
